// File: rtl/rcom_pkg.sv
// Shared types for the RCOM command receiver: FSM state encodings and byte width.
package rcom_pkg;

  typedef enum logic {WAIT_HI, WAIT_LO} asm_state_t;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

  localparam int RCOM_DATA_BITS = 8;

endpackage

// File: rtl/rcom_uart_rx.sv
// 8N1 UART byte receiver: 2-flop synchronizer, mid-bit sampling, LSB first.
// RCOM_FRAME_CHECK_EN: a 0 stop bit suppresses byte_rdy and pulses stop_bad instead.
module rcom_uart_rx
  import rcom_pkg::*;
#(
  parameter int CLKS_PER_BIT = 2604
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx,
  output logic                      byte_rdy,
  output logic [RCOM_DATA_BITS-1:0] rx_byte,
  output logic                      stop_bad
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(RCOM_DATA_BITS);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(RCOM_DATA_BITS - 1);

  logic rx_s1, rx_s2, rx_prev;
  rx_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [RCOM_DATA_BITS-1:0] shift_q, shift_d;
  logic done_d;
`ifdef RCOM_FRAME_CHECK_EN
  logic bad_d;
`endif

  // Sync flops and edge history idle high so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    done_d  = 1'b0;
`ifdef RCOM_FRAME_CHECK_EN
    bad_d   = 1'b0;
`endif
    case (state_q)
      // Only a true 1->0 transition arms a frame, so a held break yields one byte.
      IDLE: begin
        cnt_d = '0;
        if (rx_prev && !rx_s2) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s2 ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rx_s2, shift_q[RCOM_DATA_BITS-1:1]};
          if (bit_q == LAST_BIT) state_d = STOP;
          else                   bit_d   = bit_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          state_d = IDLE;
`ifdef RCOM_FRAME_CHECK_EN
          done_d  = rx_s2;
          bad_d   = !rx_s2;
`else
          done_d  = 1'b1;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      byte_rdy <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      byte_rdy <= done_d;
    end
  end

`ifdef RCOM_FRAME_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stop_bad <= 1'b0;
    else     stop_bad <= bad_d;
  end
`else
  assign stop_bad = 1'b0;
`endif

  assign rx_byte = shift_q;

endmodule

// File: rtl/rcom_cmd_rx.sv
// RCOM command receiver: pairs received bytes into {hi,lo} commands with a sticky ready flag.
// RCOM_FRAME_CHECK_EN (in rcom_uart_rx) enables stop-bit checking and frame_err.
module rcom_cmd_rx
  import rcom_pkg::*;
#(
  parameter int CLKS_PER_BIT = 2604,
  parameter int BYTE_TIMEOUT = 65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  input  logic        clr_cmd_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  output logic        timeout,
  output logic        frame_err
);

  localparam int TW = (BYTE_TIMEOUT > 1) ? $clog2(BYTE_TIMEOUT) : 1;

  logic                      byte_rdy;
  logic [RCOM_DATA_BITS-1:0] rx_byte;
  logic                      stop_bad;

  asm_state_t                state_q, state_d;
  logic [RCOM_DATA_BITS-1:0] hi_q;
  logic [TW-1:0]             tcnt_q;
  logic                      ld_hi, set_cmd, to_fire;

  rcom_uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk      (clk),
    .rst      (rst),
    .rx       (RX),
    .byte_rdy (byte_rdy),
    .rx_byte  (rx_byte),
    .stop_bad (stop_bad)
  );

  // stop_bad is tied low unless frame checking is built in.
  assign frame_err = stop_bad;

  // A byte arriving on the expiry cycle still completes the command.
  always_comb begin
    state_d = state_q;
    ld_hi   = 1'b0;
    set_cmd = 1'b0;
    to_fire = 1'b0;
    case (state_q)
      WAIT_HI: begin
        if (byte_rdy) begin
          ld_hi   = 1'b1;
          state_d = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (byte_rdy) begin
          set_cmd = 1'b1;
          state_d = WAIT_HI;
        end else if (stop_bad) begin
          state_d = WAIT_HI;
        end else if (tcnt_q == '0) begin
          to_fire = 1'b1;
          state_d = WAIT_HI;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WAIT_HI;
      hi_q    <= '0;
      tcnt_q  <= '0;
      cmd     <= '0;
      cmd_rdy <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      timeout <= to_fire;
      if (ld_hi) begin
        hi_q   <= rx_byte;
        tcnt_q <= TW'(BYTE_TIMEOUT - 1);
      end else if (state_q == WAIT_LO && tcnt_q != '0) begin
        tcnt_q <= tcnt_q - 1'b1;
      end
      // A completing command beats a same-cycle acknowledge.
      if (set_cmd) begin
        cmd     <= {hi_q, rx_byte};
        cmd_rdy <= 1'b1;
      end else if (ld_hi || clr_cmd_rdy) begin
        cmd_rdy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rcom_cmd_rx.sv
// Bench for rcom_cmd_rx: byte-pair model checked every cycle plus literal end-of-test checks.
module tb_rcom_cmd_rx;

  localparam int CPB = 16;
  localparam int TMO = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic        RX;
  logic        clr_cmd_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy, timeout, frame_err;

  int n_cmp = 0;
  int n_err = 0;

  rcom_cmd_rx #(.CLKS_PER_BIT(CPB), .BYTE_TIMEOUT(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .RX          (RX),
    .clr_cmd_rdy (clr_cmd_rdy),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .timeout     (timeout),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: bytes the bench put on the line, in order; each pair forms a command.
  typedef struct {logic [7:0] d; logic bad;} ent_t;
  ent_t q[$];

  logic [15:0] e_cmd = '0;
  logic        e_rdy = 1'b0;
  logic        e_to  = 1'b0;
  logic        m_lo  = 1'b0;
  logic [7:0]  m_hi  = '0;
  int          m_age = 0;
  int          to_cnt = 0;
  int          fe_cnt = 0;

  always @(negedge clk) begin
    ent_t e;
    bit   set_now;
    set_now = 1'b0;
    if (rst) begin
      chk("rst_cmd", cmd, 0);
      chk("rst_cmd_rdy", cmd_rdy, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_frame_err", frame_err, 0);
      e_cmd = '0; e_rdy = 1'b0; e_to = 1'b0; m_lo = 1'b0; m_age = 0;
      q.delete();
    end else begin
      chk("cmd", cmd, e_cmd);
      chk("cmd_rdy", cmd_rdy, e_rdy);
      chk("timeout", timeout, e_to);
      if (timeout) to_cnt++;
      e_to = 1'b0;
`ifdef RCOM_FRAME_CHECK_EN
      if (frame_err) begin
        fe_cnt++;
        chk("frame_err_on_bad_stop", (q.size() > 0) && q[0].bad, 1);
        if (q.size() > 0) void'(q.pop_front());
        m_lo = 1'b0;
      end
`else
      chk("frame_err", frame_err, 0);
`endif
      if (dut.byte_rdy) begin
        chk("byte_expected", q.size() != 0, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
`ifdef RCOM_FRAME_CHECK_EN
          chk("byte_good_stop", e.bad, 0);
`endif
          if (!m_lo) begin
            m_hi = e.d; m_lo = 1'b1; m_age = 0; e_rdy = 1'b0;
          end else begin
            e_cmd = {m_hi, e.d}; e_rdy = 1'b1; m_lo = 1'b0; set_now = 1'b1;
          end
        end
      end else if (m_lo) begin
        m_age++;
        if (m_age == TMO) begin e_to = 1'b1; m_lo = 1'b0; end
      end
      if (clr_cmd_rdy && !set_now) e_rdy = 1'b0;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One 8N1 frame; abort_at >= 0 asserts rst halfway through that bit slot.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int abort_at);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    q.push_back('{b, !stop});
    for (int i = 0; i < 10; i++) begin
      RX = bits[i];
      if (i == abort_at) begin
        idle(CPB / 2);
        rst = 1'b1;
        idle(3);
        RX  = 1'b1;
        rst = 1'b0;
        idle(5);
        return;
      end
      idle(CPB);
    end
    RX = 1'b1;
  endtask

  task automatic send_pair(input logic [7:0] h, input logic [7:0] l);
    send_frame(h, 1'b1, -1);
    send_frame(l, 1'b1, -1);
    idle(20);
  endtask

  task automatic pulse_clr();
    clr_cmd_rdy = 1'b1;
    idle(1);
    clr_cmd_rdy = 1'b0;
    idle(2);
  endtask

  int t0, f0;

  initial begin
    rst = 1'b1; RX = 1'b1; clr_cmd_rdy = 1'b0;
    idle(3);
    rst = 1'b0;
    idle(5);

    send_pair(8'h23, 8'h45);
    chk("pair1_cmd", cmd, 16'h2345);
    chk("pair1_rdy", cmd_rdy, 1);
    chk("pair1_no_timeout", to_cnt, 0);

    pulse_clr();
    chk("clr_rdy", cmd_rdy, 0);
    chk("clr_cmd_hold", cmd, 16'h2345);
    send_pair(8'hA5, 8'h5A);
    chk("pair2_cmd", cmd, 16'hA55A);
    chk("pair2_rdy", cmd_rdy, 1);

    // Acknowledge lands on the same edge as the low-byte completion.
    fork
      begin
        int n = 0;
        for (int c = 0; c < 1000 && n < 2; c++) begin
          @(posedge clk); #1;
          if (dut.byte_rdy) begin
            n++;
            if (n == 2) clr_cmd_rdy = 1'b1;
          end
        end
        @(posedge clk); #1;
        clr_cmd_rdy = 1'b0;
      end
    join_none
    send_pair(8'h5A, 8'hA5);
    chk("coincide_cmd", cmd, 16'h5AA5);
    chk("coincide_rdy", cmd_rdy, 1);
    pulse_clr();

    t0 = to_cnt;
    send_frame(8'h12, 1'b1, -1);
    idle(300);
    chk("timeout_pulses", to_cnt - t0, 1);
    chk("timeout_cmd_hold", cmd, 16'h5AA5);
    chk("timeout_rdy", cmd_rdy, 0);
    send_pair(8'hBE, 8'hEF);
    chk("after_to_cmd", cmd, 16'hBEEF);

    RX = 1'b0;
    idle(3);
    RX = 1'b1;
    idle(30);
    chk("glitch_cmd", cmd, 16'hBEEF);
    chk("glitch_rdy", cmd_rdy, 1);
    send_pair(8'h00, 8'hFF);
    chk("pair_00ff", cmd, 16'h00FF);

    send_frame(8'h9C, 1'b1, -1);
    send_frame(8'h77, 1'b1, 5);
    chk("abort_cmd", cmd, 16'h0000);
    chk("abort_rdy", cmd_rdy, 0);
    send_pair(8'h34, 8'h56);
    chk("post_rst_cmd", cmd, 16'h3456);
    chk("post_rst_rdy", cmd_rdy, 1);

    f0 = fe_cnt;
    send_frame(8'h11, 1'b0, -1);
    idle(20);
    send_frame(8'h22, 1'b1, -1);
    send_frame(8'h33, 1'b1, -1);
    idle(20);
`ifdef RCOM_FRAME_CHECK_EN
    chk("fe_cmd", cmd, 16'h2233);
    chk("fe_pulses", fe_cnt - f0, 1);
`else
    chk("nofe_cmd", cmd, 16'h1122);
    chk("nofe_pulses", fe_cnt - f0, 0);
`endif
    idle(250);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
